// File: rtl/la_clkor4_ctrl_pkg.sv
// rtl/la_clkor4_ctrl_pkg.sv - shared types, constants and helpers for the clock-OR enable sequencer
// Purpose: state encoding, counter width and the one-hot decode used by the top and the counter.
// Ports: none (package).
package la_clkor4_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ON     = 2'd1,
    DRAIN  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/la_clkor4_ctrl_cnt.sv
// rtl/la_clkor4_ctrl_cnt.sv - loadable down-counter with zero flag for drain/settle timing
// Purpose: one counter serves both the drain and the settle interval; it saturates at zero.
// Ports:
//   clk      in   control clock
//   reset    in   synchronous active-high reset (loads RST_VAL)
//   load     in   load load_val this cycle (takes priority over decrement)
//   load_val in   CNT_W value to load
//   zero     out  counter currently holds zero
module la_clkor4_ctrl_cnt
  import la_clkor4_ctrl_pkg::*;
#(
  parameter             PROP    = "DEFAULT",
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (!zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Cell-mapped builds may substitute a library zero detect; behaviour is the same.
  if (PROP == "DEFAULT") begin : g_zero_std
    assign zero = (cnt_q == '0);
  end else begin : g_zero_cell
    assign zero = ~|cnt_q;
  end

endmodule

// File: rtl/la_clkor4_ctrl.sv
// rtl/la_clkor4_ctrl.sv - break-before-make sequencer for four clock-gate enables feeding a clock OR
// Purpose: at most one enable high; every switch drops all enables for a drain interval, then
//   raises the new enable and waits a settle interval before reporting active.
// Optional: define LA_CLKOR4_CTRL_ACK_EN to add gate enable feedback (en_ack) and a sticky ack_err.
// Ports:
//   clk       in   always-on control clock
//   reset     in   synchronous active-high reset
//   req_valid in   switch request valid
//   req_ready out  request accepted when req_valid & req_ready (OFF/ON only)
//   req_sel   in   requested source index
//   req_off   in   request all sources off (req_sel ignored)
//   en        out  clock-gate enables, one-hot or zero
//   cur_sel   out  current or last selected source
//   active    out  selected source enabled and settled
//   busy      out  switch in progress
//   en_ack    in   (ACK_EN) gate enable feedback, synchronized to clk
//   ack_err   out  (ACK_EN) sticky: a non-selected gate acknowledged while ON
module la_clkor4_ctrl
  import la_clkor4_ctrl_pkg::*;
#(
  parameter     PROP          = "DEFAULT",
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESET_SEL     = 0,
  parameter int RESET_ON      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_off,
  output logic [3:0] en,
  output logic [1:0] cur_sel,
  output logic       active,
  output logic       busy
`ifdef LA_CLKOR4_CTRL_ACK_EN
  ,
  input  logic [3:0] en_ack,
  output logic       ack_err
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_LD  = DRAIN_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SETTLE_LD = SETTLE_CYCLES[CNT_W-1:0];
  localparam logic [1:0]       RST_SEL   = RESET_SEL[1:0];
  localparam bit               RST_ON    = (RESET_ON != 0);
  localparam state_t           RST_STATE = RST_ON ? SETTLE : OFF;
  localparam logic [3:0]       RST_EN    = RST_ON ? onehot4(RST_SEL) : 4'b0000;
  localparam logic [CNT_W-1:0] RST_CNT   = RST_ON ? SETTLE_LD : '0;

  state_t           state_q, state_d;
  logic [1:0]       target_q, target_d;
  logic             off_q, off_d;
  logic [1:0]       cur_sel_d;
  logic [3:0]       en_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             drain_ok;
  logic             settle_ok;
  logic             accept;

  assign accept = req_valid && req_ready;

`ifdef LA_CLKOR4_CTRL_ACK_EN
  // The gates must confirm they are really off / really on before moving on.
  assign drain_ok  = (en_ack == 4'b0000);
  assign settle_ok = en_ack[cur_sel];
`else
  assign drain_ok  = 1'b1;
  assign settle_ok = 1'b1;
`endif

  la_clkor4_ctrl_cnt #(
    .PROP    (PROP),
    .RST_VAL (RST_CNT)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    off_d     = off_q;
    cur_sel_d = cur_sel;
    en_d      = en;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state_q)
      OFF: begin
        // An off request while already off is a no-op.
        if (accept && !req_off) begin
          target_d  = req_sel;
          cur_sel_d = req_sel;
          en_d      = onehot4(req_sel);
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LD;
          state_d   = SETTLE;
        end
      end
      ON: begin
        if (accept && (req_off || (req_sel != cur_sel))) begin
          en_d     = 4'b0000;
          target_d = req_sel;
          off_d    = req_off;
          cnt_load = 1'b1;
          cnt_val  = DRAIN_LD;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_zero && drain_ok) begin
          if (off_q) begin
            state_d = OFF;
          end else begin
            en_d      = onehot4(target_q);
            cur_sel_d = target_q;
            cnt_load  = 1'b1;
            cnt_val   = SETTLE_LD;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero && settle_ok) begin
          state_d = ON;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_STATE;
      target_q  <= RST_SEL;
      off_q     <= 1'b0;
      cur_sel   <= RST_SEL;
      en        <= RST_EN;
      active    <= 1'b0;
      busy      <= RST_ON;
      req_ready <= !RST_ON;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      off_q     <= off_d;
      cur_sel   <= cur_sel_d;
      en        <= en_d;
      active    <= (state_d == ON);
      busy      <= (state_d == DRAIN) || (state_d == SETTLE);
      req_ready <= (state_d == OFF) || (state_d == ON);
    end
  end

`ifdef LA_CLKOR4_CTRL_ACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_err <= 1'b0;
    end else if ((state_q == ON) && |(en_ack & ~onehot4(cur_sel))) begin
      ack_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_la_clkor4_ctrl.sv
// tb/tb_la_clkor4_ctrl.sv - directed self-checking bench for la_clkor4_ctrl
module tb_la_clkor4_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       reset, req_valid, req_ready, req_off, active, busy;
  logic [1:0] req_sel, cur_sel;
  logic [3:0] en;

  // RESET_ON=1, RESET_SEL=3 instance
  logic       r_reset, r_req_valid, r_req_ready, r_req_off, r_active, r_busy;
  logic [1:0] r_req_sel, r_cur_sel;
  logic [3:0] r_en;

`ifdef LA_CLKOR4_CTRL_ACK_EN
  logic [3:0] ack_force = 4'b0000;
  logic [3:0] en_ack, r_en_ack;
  logic       ack_err, r_ack_err;
  assign en_ack   = en | ack_force;
  assign r_en_ack = r_en;
`endif

  la_clkor4_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_off   (req_off),
    .en        (en),
    .cur_sel   (cur_sel),
    .active    (active),
    .busy      (busy)
`ifdef LA_CLKOR4_CTRL_ACK_EN
    ,
    .en_ack    (en_ack),
    .ack_err   (ack_err)
`endif
  );

  la_clkor4_ctrl #(
    .RESET_SEL (3),
    .RESET_ON  (1)
  ) dut_r (
    .clk       (clk),
    .reset     (r_reset),
    .req_valid (r_req_valid),
    .req_ready (r_req_ready),
    .req_sel   (r_req_sel),
    .req_off   (r_req_off),
    .en        (r_en),
    .cur_sel   (r_cur_sel),
    .active    (r_active),
    .busy      (r_busy)
`ifdef LA_CLKOR4_CTRL_ACK_EN
    ,
    .en_ack    (r_en_ack),
    .ack_err   (r_ack_err)
`endif
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       chk_on  = 1'b0;
  logic [3:0] en_prev = 4'b0000;
  logic [3:0] r_en_prev = 4'b0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] sel, input logic off);
    req_valid = 1'b1;
    req_sel   = sel;
    req_off   = off;
    tick();
    req_valid = 1'b0;
    req_off   = 1'b0;
  endtask

  // Counts cycles from the current (acceptance) sample until active, and en==0 samples on the way.
  task automatic wait_active(output int n, output int zeros);
    n = 0;
    zeros = 0;
    while (!active && n < 100) begin
      if (en == 4'b0000) zeros++;
      check("busy_during_switch", 32'(busy), 32'd1);
      tick();
      n++;
    end
  endtask

  // Every-cycle invariants: never more than one enable, never a direct source-to-source hop.
  always @(negedge clk) begin
    if (chk_on) begin
      check("onehot_en",   ($countones(en)   <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("onehot_r_en", ($countones(r_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("bbm_en",   (en_prev   != 0 && en   != 0 && en   != en_prev)   ? 32'd0 : 32'd1, 32'd1);
      check("bbm_r_en", (r_en_prev != 0 && r_en != 0 && r_en != r_en_prev) ? 32'd0 : 32'd1, 32'd1);
      en_prev   = en;
      r_en_prev = r_en;
    end
  end

  initial begin
    int n, z, z2;
    reset = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_off = 1'b0;
    r_reset = 1'b1; r_req_valid = 1'b0; r_req_sel = 2'd0; r_req_off = 1'b0;
    tick();
    tick();

    // Reset state, both configurations
    check("rst_en",        32'(en),          32'h0);
    check("rst_ready",     32'(req_ready),   32'd1);
    check("rst_active",    32'(active),      32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_cur_sel",   32'(cur_sel),     32'd0);
    check("r_rst_en",      32'(r_en),        32'h8);
    check("r_rst_busy",    32'(r_busy),      32'd1);
    check("r_rst_ready",   32'(r_req_ready), 32'd0);
    check("r_rst_active",  32'(r_active),    32'd0);
    check("r_rst_cur_sel", 32'(r_cur_sel),   32'd3);
    en_prev   = en;
    r_en_prev = r_en;
    chk_on  = 1'b1;
    reset   = 1'b0;
    r_reset = 1'b0;

    n = 0;
    while (!r_active && n < 100) begin tick(); n++; end
    check("r_boot_to_active", 32'(n), 32'd3);

    // OFF -> sel 2
    request(2'd2, 1'b0);
    check("off2_en",    32'(en),        32'h4);
    check("off2_sel",   32'(cur_sel),   32'd2);
    check("off2_ready", 32'(req_ready), 32'd0);
    wait_active(n, z);
    check("off2_cycles", 32'(n), 32'd3);
    check("off2_zeros",  32'(z), 32'd0);
    check("on2_busy",    32'(busy),      32'd0);
    check("on2_ready",   32'(req_ready), 32'd1);

    // sel 2 -> sel 0
    request(2'd0, 1'b0);
    check("sw20_en0",  32'(en),   32'h0);
    check("sw20_busy", 32'(busy), 32'd1);
    wait_active(n, z);
    check("sw20_cycles", 32'(n),       32'd8);
    check("sw20_gap",    32'(z),       32'd5);
    check("sw20_en",     32'(en),      32'h1);
    check("sw20_sel",    32'(cur_sel), 32'd0);

    // sel 0 -> sel 1, then same-source request is a no-op
    request(2'd1, 1'b0);
    wait_active(n, z);
    check("sw01_cycles", 32'(n), 32'd8);
    request(2'd1, 1'b0);
    check("same_busy",   32'(busy),      32'd0);
    check("same_ready",  32'(req_ready), 32'd1);
    check("same_en",     32'(en),        32'h2);
    check("same_active", 32'(active),    32'd1);

    // All off
    request(2'd0, 1'b1);
    check("off_en0",     32'(en),     32'h0);
    check("off_active0", 32'(active), 32'd0);
    check("off_busy",    32'(busy),   32'd1);
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("off_cycles",  32'(n),       32'd5);
    check("off_en",      32'(en),      32'h0);
    check("off_busy_end", 32'(busy),   32'd0);
    check("off_active",  32'(active),  32'd0);
    check("off_cur_sel", 32'(cur_sel), 32'd1);

    // Off request while already OFF
    request(2'd2, 1'b1);
    check("offoff_ready", 32'(req_ready), 32'd1);
    check("offoff_busy",  32'(busy),      32'd0);
    check("offoff_en",    32'(en),        32'h0);

    // Request held through a switch is taken on the first ON cycle
    request(2'd0, 1'b0);
    wait_active(n, z);
    check("on0_cycles", 32'(n), 32'd3);
    req_valid = 1'b1;
    req_sel   = 2'd1;
    tick();
    req_sel = 2'd3;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("held_wait",   32'(n),      32'd8);
    check("held_en",     32'(en),     32'h2);
    check("held_active", 32'(active), 32'd1);
    tick();
    req_valid = 1'b0;
    check("held_acc_en",   32'(en),      32'h0);
    check("held_acc_busy", 32'(busy),    32'd1);
    check("held_acc_sel",  32'(cur_sel), 32'd1);
    wait_active(n, z);
    check("held_cycles", 32'(n),       32'd8);
    check("held_gap",    32'(z),       32'd5);
    check("held_en3",    32'(en),      32'h8);
    check("held_sel3",   32'(cur_sel), 32'd3);

    // Reset in the second DRAIN cycle of the RESET_ON instance
    r_req_valid = 1'b1;
    r_req_sel   = 2'd0;
    tick();
    r_req_valid = 1'b0;
    check("r_drain_en", 32'(r_en), 32'h0);
    tick();
    r_reset = 1'b1;
    tick();
    r_reset = 1'b0;
    check("r_mid_en",     32'(r_en),        32'h8);
    check("r_mid_busy",   32'(r_busy),      32'd1);
    check("r_mid_active", 32'(r_active),    32'd0);
    check("r_mid_ready",  32'(r_req_ready), 32'd0);
    check("r_mid_sel",    32'(r_cur_sel),   32'd3);
    n = 0;
    while (!r_active && n < 100) begin tick(); n++; end
    check("r_mid_to_active", 32'(n), 32'd3);

`ifdef LA_CLKOR4_CTRL_ACK_EN
    // Old gate keeps acknowledging past the drain count
    request(2'd0, 1'b0);
    ack_force = 4'b1000;
    z = 0;
    for (int i = 0; i < 14; i++) begin
      if (en == 4'b0000) z++;
      tick();
    end
    ack_force = 4'b0000;
    wait_active(n, z2);
    check("ack_gap",    32'(z + z2), 32'd15);
    check("ack_cycles", 32'(14 + n), 32'd18);
    check("ack_en",     32'(en),     32'h1);

    // Spurious acknowledge from a non-selected gate
    check("ack_err_clr", 32'(ack_err), 32'd0);
    ack_force = 4'b0100;
    tick();
    ack_force = 4'b0000;
    check("ack_err_set", 32'(ack_err), 32'd1);
    tick();
    tick();
    check("ack_err_sticky", 32'(ack_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ack_err_reset", 32'(ack_err), 32'd0);
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
